power_pulsing_sequencer: RTL and testbench
==========================================

POWER_PULSING_SEQUENCER -- requirements
Module: power_pulsing_sequencer

Interface
REQ-001 Parameter COUNTER_WIDTH, default 16, width of every delay input and of the dwell counter.
REQ-002 Clk  input  1  system clock; all logic on rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset.
REQ-004 PowerPulsingEnable  input  1  1 = sequencer drives power lines; 0 = all rails forced on.
REQ-005 AcqStart  input  1  single-cycle request to power up for acquisition.
REQ-006 AcqStop  input  1  single-cycle request to power down.
REQ-007 DigitalDelay  input  COUNTER_WIDTH  extra dwell cycles after digital rail on.
REQ-008 AnalogDelay  input  COUNTER_WIDTH  extra dwell cycles after analog and DAC rails on.
REQ-009 AdcDelay  input  COUNTER_WIDTH  extra dwell cycles after ADC rail on.
REQ-010 ShutdownDelay  input  COUNTER_WIDTH  extra dwell cycles between power-down steps.
REQ-011 PowerOnDigital, PowerOnAnalog, PowerOnDac, PowerOnAdc  output  1 each  registered rail enables feeding the ASIC power-on mux.
REQ-012 PowerReady  output  1  registered; 1 only in READY state or when pulsing disabled.
REQ-013 SequencerBusy  output  1  registered; 1 in any state other than IDLE and READY.

Function
REQ-014 States: IDLE, DIG_ON, ANA_ON, ADC_ON, READY, ADC_OFF, ANA_OFF, DIG_OFF.
REQ-015 Rail levels per state: IDLE all 0; DIG_ON D; ANA_ON D,A,DAC; ADC_ON and READY D,A,DAC,ADC; ADC_OFF D,A,DAC; ANA_OFF D; DIG_OFF all 0.
REQ-016 Outputs registered: rail levels of a state appear the cycle after its entry edge.
REQ-017 Dwell: on entry to a timed state, counter loads its delay input; state exits when counter is 0; dwell = delay+1 cycles; delay 0 gives 1-cycle dwell.
REQ-018 Delay inputs sampled only at state entry; changes mid-dwell take no effect.
REQ-019 Timed states and delays: DIG_ON DigitalDelay, ANA_ON AnalogDelay, ADC_ON AdcDelay, ADC_OFF and ANA_OFF ShutdownDelay; DIG_OFF fixed 1 cycle then IDLE.
REQ-020 IDLE -> DIG_ON on AcqStart=1 and AcqStop=0; AcqStart and AcqStop both 1 in IDLE: stop wins, remain IDLE.
REQ-021 READY held until AcqStop; READY -> ADC_OFF on AcqStop.
REQ-022 AcqStop during DIG_ON, ANA_ON or ADC_ON: abort next edge into power-down state matching current rails (ADC_ON -> ADC_OFF, ANA_ON -> ANA_OFF, DIG_ON -> DIG_OFF).
REQ-023 AcqStart in READY or any power-up state: ignored.
REQ-024 AcqStart during ADC_OFF, ANA_OFF or DIG_OFF: set 1-bit pending flag; on reaching IDLE with flag set, go to DIG_ON next edge and clear flag; AcqStop in a power-down state clears flag.
REQ-025 PowerPulsingEnable=0: next edge forces IDLE, clears counter and pending flag; rails, PowerReady = 1; SequencerBusy = 0; AcqStart/AcqStop ignored.
REQ-026 PowerPulsingEnable 0->1: start in IDLE with all rails 0 the following cycle.
REQ-027 Counter never wraps; it decrements only while nonzero.

Reset
REQ-028 reset_n=0 at an edge: state IDLE, counter 0, pending flag 0, all rails 0, PowerReady 0, SequencerBusy 0, regardless of PowerPulsingEnable.
REQ-029 Reset mid-sequence drops all rails at the same edge; no ordered shutdown.
REQ-030 After reset release, REQ-025 applies from the first edge if PowerPulsingEnable=0.

Structure
REQ-031 State encoding constants and COUNTER_WIDTH default in shared package power_pulsing_pkg.
REQ-032 One sub-module, dwell_counter (load, decrement, zero flag), instantiated once.

Verification
REQ-033 Enable=1, delays D=3,A=5,ADC=2, AcqStart -> Digital high cycle+1, Analog/DAC at +5, ADC at +11, PowerReady at +14.
REQ-034 In READY, AcqStop, ShutdownDelay=4 -> ADC low +1, Analog/DAC low +6, Digital low +11, IDLE +12.
REQ-035 All delays 0, AcqStart -> PowerReady 4 cycles after start, Busy high 3 cycles.
REQ-036 AcqStop during ANA_ON -> next edge ANA_OFF, ADC never asserted, Digital low after ShutdownDelay+2 cycles.
REQ-037 AcqStart during ANA_OFF -> after IDLE, automatic DIG_ON; no AcqStart replay if AcqStop followed.
REQ-038 Enable dropped in ADC_ON -> all rails and PowerReady 1 next cycle; re-enable -> all rails 0, IDLE; reset_n=0 mid-sequence -> all outputs 0 next cycle.

Source files
------------

// File: rtl/power_pulsing_pkg.sv
// Shared definitions for the power pulsing sequencer: state encoding, rail
// bit positions and the per-state rail decode.
package power_pulsing_pkg;

    localparam int COUNTER_WIDTH_DEFAULT = 16;

    localparam int NUM_RAILS   = 4;
    localparam int RAIL_DIGITAL = 0;
    localparam int RAIL_ANALOG  = 1;
    localparam int RAIL_DAC     = 2;
    localparam int RAIL_ADC     = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DIG_ON  = 3'd1,
        ST_ANA_ON  = 3'd2,
        ST_ADC_ON  = 3'd3,
        ST_READY   = 3'd4,
        ST_ADC_OFF = 3'd5,
        ST_ANA_OFF = 3'd6,
        ST_DIG_OFF = 3'd7
    } seqState_t;

    // Power-down states mirror the power-up states one rail group lower.
    function automatic logic [NUM_RAILS-1:0] railsForState(input seqState_t state);
        logic [NUM_RAILS-1:0] rails;
        rails = '0;
        case (state)
            ST_DIG_ON,
            ST_ANA_OFF: rails = 4'b0001;
            ST_ANA_ON,
            ST_ADC_OFF: rails = 4'b0111;
            ST_ADC_ON,
            ST_READY:   rails = 4'b1111;
            default:    rails = 4'b0000;
        endcase
        return rails;
    endfunction

    function automatic logic isBusyState(input seqState_t state);
        return !((state == ST_IDLE) || (state == ST_READY));
    endfunction

endpackage

// File: rtl/dwell_counter.sv
// Dwell timer for the sequencer: loads a delay on state entry, counts down
// to zero and holds there.
module dwell_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] loadValue,
    output logic             isZero
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] countReg;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            countReg <= '0;
        end else if (clear) begin
            countReg <= '0;
        end else if (load) begin
            countReg <= loadValue;
        end else if (countReg != '0) begin
            countReg <= countReg - ONE;
        end
    end

    assign isZero = (countReg == '0);

endmodule

// File: rtl/power_pulsing_sequencer.sv
// Ordered power-up / power-down of the ASIC rails (digital, analog+DAC, ADC)
// with programmable dwell per step; all outputs are registered.
module power_pulsing_sequencer
    import power_pulsing_pkg::*;
#(
    parameter int COUNTER_WIDTH = COUNTER_WIDTH_DEFAULT
) (
    input  logic                     Clk,
    input  logic                     reset_n,
    input  logic                     PowerPulsingEnable,
    input  logic                     AcqStart,
    input  logic                     AcqStop,
    input  logic [COUNTER_WIDTH-1:0] DigitalDelay,
    input  logic [COUNTER_WIDTH-1:0] AnalogDelay,
    input  logic [COUNTER_WIDTH-1:0] AdcDelay,
    input  logic [COUNTER_WIDTH-1:0] ShutdownDelay,
    output logic                     PowerOnDigital,
    output logic                     PowerOnAnalog,
    output logic                     PowerOnDac,
    output logic                     PowerOnAdc,
    output logic                     PowerReady,
    output logic                     SequencerBusy
);

    seqState_t stateReg, stateNext;
    logic      pendingReg, pendingNext;
    logic      cntLoad;
    logic      cntZero;
    logic [COUNTER_WIDTH-1:0] cntLoadValue;
    logic [NUM_RAILS-1:0]     railsNext;
    logic [NUM_RAILS-1:0]     railsReg;
    logic      readyReg, busyReg;

    dwell_counter #(
        .WIDTH(COUNTER_WIDTH)
    ) uDwellCounter (
        .clk      (Clk),
        .reset_n  (reset_n),
        .clear    (!PowerPulsingEnable),
        .load     (cntLoad),
        .loadValue(cntLoadValue),
        .isZero   (cntZero)
    );

    always_comb begin
        stateNext    = stateReg;
        pendingNext  = pendingReg;
        cntLoad      = 1'b0;
        cntLoadValue = '0;

        // A start seen while powering down is remembered; a later stop cancels it.
        if ((stateReg == ST_ADC_OFF) || (stateReg == ST_ANA_OFF) || (stateReg == ST_DIG_OFF)) begin
            if (AcqStop) begin
                pendingNext = 1'b0;
            end else if (AcqStart) begin
                pendingNext = 1'b1;
            end
        end

        case (stateReg)
            ST_IDLE: begin
                if (AcqStop) begin
                    pendingNext = 1'b0;
                end else if (AcqStart || pendingReg) begin
                    stateNext    = ST_DIG_ON;
                    cntLoad      = 1'b1;
                    cntLoadValue = DigitalDelay;
                    pendingNext  = 1'b0;
                end
            end
            ST_DIG_ON: begin
                if (AcqStop) begin
                    stateNext = ST_DIG_OFF;
                    cntLoad   = 1'b1;
                end else if (cntZero) begin
                    stateNext    = ST_ANA_ON;
                    cntLoad      = 1'b1;
                    cntLoadValue = AnalogDelay;
                end
            end
            ST_ANA_ON: begin
                if (AcqStop) begin
                    stateNext    = ST_ANA_OFF;
                    cntLoad      = 1'b1;
                    cntLoadValue = ShutdownDelay;
                end else if (cntZero) begin
                    stateNext    = ST_ADC_ON;
                    cntLoad      = 1'b1;
                    cntLoadValue = AdcDelay;
                end
            end
            ST_ADC_ON: begin
                if (AcqStop) begin
                    stateNext    = ST_ADC_OFF;
                    cntLoad      = 1'b1;
                    cntLoadValue = ShutdownDelay;
                end else if (cntZero) begin
                    stateNext = ST_READY;
                end
            end
            ST_READY: begin
                if (AcqStop) begin
                    stateNext    = ST_ADC_OFF;
                    cntLoad      = 1'b1;
                    cntLoadValue = ShutdownDelay;
                end
            end
            ST_ADC_OFF: begin
                if (cntZero) begin
                    stateNext    = ST_ANA_OFF;
                    cntLoad      = 1'b1;
                    cntLoadValue = ShutdownDelay;
                end
            end
            ST_ANA_OFF: begin
                if (cntZero) begin
                    stateNext = ST_DIG_OFF;
                    cntLoad   = 1'b1;
                end
            end
            ST_DIG_OFF: begin
                stateNext = ST_IDLE;
            end
            default: begin
                stateNext = ST_IDLE;
            end
        endcase
    end

    // With pulsing disabled every rail is held on and the FSM parks in IDLE.
    always_ff @(posedge Clk) begin
        if (!reset_n) begin
            stateReg   <= ST_IDLE;
            pendingReg <= 1'b0;
            readyReg   <= 1'b0;
            busyReg    <= 1'b0;
        end else if (!PowerPulsingEnable) begin
            stateReg   <= ST_IDLE;
            pendingReg <= 1'b0;
            readyReg   <= 1'b1;
            busyReg    <= 1'b0;
        end else begin
            stateReg   <= stateNext;
            pendingReg <= pendingNext;
            readyReg   <= (stateNext == ST_READY);
            busyReg    <= isBusyState(stateNext);
        end
    end

    // Rails are decoded from the next state so they change on the entry edge.
    assign railsNext = PowerPulsingEnable ? railsForState(stateNext) : '1;

    for (genvar gi = 0; gi < NUM_RAILS; gi++) begin : gRail
        logic railReg;
        always_ff @(posedge Clk) begin
            if (!reset_n) begin
                railReg <= 1'b0;
            end else begin
                railReg <= railsNext[gi];
            end
        end
        assign railsReg[gi] = railReg;
    end

    assign PowerOnDigital = railsReg[RAIL_DIGITAL];
    assign PowerOnAnalog  = railsReg[RAIL_ANALOG];
    assign PowerOnDac     = railsReg[RAIL_DAC];
    assign PowerOnAdc     = railsReg[RAIL_ADC];
    assign PowerReady     = readyReg;
    assign SequencerBusy  = busyReg;

endmodule

// File: tb/tb_power_pulsing_sequencer.sv
// Self-checking bench for power_pulsing_sequencer: timing table, corner-case
// sequences and a randomized run against a rail-level reference model.
module tb_power_pulsing_sequencer;

    localparam int CW = 16;

    logic          Clk = 1'b0;
    logic          reset_n;
    logic          PowerPulsingEnable;
    logic          AcqStart;
    logic          AcqStop;
    logic [CW-1:0] DigitalDelay;
    logic [CW-1:0] AnalogDelay;
    logic [CW-1:0] AdcDelay;
    logic [CW-1:0] ShutdownDelay;
    logic          PowerOnDigital;
    logic          PowerOnAnalog;
    logic          PowerOnDac;
    logic          PowerOnAdc;
    logic          PowerReady;
    logic          SequencerBusy;

    int testsRun    = 0;
    int testsFailed = 0;

    always #5 Clk = ~Clk;

    power_pulsing_sequencer #(.COUNTER_WIDTH(CW)) dut (
        .Clk               (Clk),
        .reset_n           (reset_n),
        .PowerPulsingEnable(PowerPulsingEnable),
        .AcqStart          (AcqStart),
        .AcqStop           (AcqStop),
        .DigitalDelay      (DigitalDelay),
        .AnalogDelay       (AnalogDelay),
        .AdcDelay          (AdcDelay),
        .ShutdownDelay     (ShutdownDelay),
        .PowerOnDigital    (PowerOnDigital),
        .PowerOnAnalog     (PowerOnAnalog),
        .PowerOnDac        (PowerOnDac),
        .PowerOnAdc        (PowerOnAdc),
        .PowerReady        (PowerReady),
        .SequencerBusy     (SequencerBusy)
    );

    // Reference model: how many rail groups are on (0..3), which way the
    // sequence is moving, and how many cycles remain in the current step.
    localparam int D_IDLE = 0, D_UP = 1, D_HOLD = 2, D_DOWN = 3;
    int         mLevel = 0;
    int         mDir   = D_IDLE;
    int         mRem   = 0;
    bit         mPend  = 1'b0;
    logic [5:0] mOut   = 6'b0;

    task automatic enterUp(input int level);
        mDir   = D_UP;
        mLevel = level;
        if (level == 1)      mRem = int'(DigitalDelay) + 1;
        else if (level == 2) mRem = int'(AnalogDelay) + 1;
        else                 mRem = int'(AdcDelay) + 1;
    endtask

    task automatic enterDown(input int level);
        mDir   = D_DOWN;
        mLevel = level;
        mRem   = (level == 0) ? 1 : int'(ShutdownDelay) + 1;
    endtask

    task automatic modelStep();
        if (!reset_n) begin
            mDir = D_IDLE; mLevel = 0; mRem = 0; mPend = 1'b0; mOut = 6'b000000;
            return;
        end
        if (!PowerPulsingEnable) begin
            mDir = D_IDLE; mLevel = 0; mRem = 0; mPend = 1'b0; mOut = 6'b111110;
            return;
        end
        case (mDir)
            D_IDLE: begin
                if (AcqStop) mPend = 1'b0;
                else if (AcqStart || mPend) begin
                    mPend = 1'b0;
                    enterUp(1);
                end
            end
            D_UP: begin
                if (AcqStop) enterDown(mLevel - 1);
                else if (mRem == 1) begin
                    if (mLevel == 3) mDir = D_HOLD;
                    else             enterUp(mLevel + 1);
                end else mRem--;
            end
            D_HOLD: begin
                if (AcqStop) enterDown(2);
            end
            default: begin
                if (AcqStop)       mPend = 1'b0;
                else if (AcqStart) mPend = 1'b1;
                if (mRem == 1) begin
                    if (mLevel == 0) mDir = D_IDLE;
                    else             enterDown(mLevel - 1);
                end else mRem--;
            end
        endcase
        mOut = {mLevel >= 1, mLevel >= 2, mLevel >= 2, mLevel >= 3,
                mDir == D_HOLD, (mDir == D_UP) || (mDir == D_DOWN)};
    endtask

    function automatic logic [5:0] dutOut();
        return {PowerOnDigital, PowerOnAnalog, PowerOnDac, PowerOnAdc, PowerReady, SequencerBusy};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock: advance the model on the same inputs, then compare after the edge.
    task automatic tick();
        modelStep();
        @(posedge Clk);
        #1;
        check("model", 32'(dutOut()), 32'(mOut));
    endtask

    task automatic setDelays(input int d, input int a, input int c, input int s);
        DigitalDelay  = CW'(d);
        AnalogDelay   = CW'(a);
        AdcDelay      = CW'(c);
        ShutdownDelay = CW'(s);
    endtask

    typedef struct {
        int dig, ana, adc, sd;
        int eDigUp, eAnaUp, eAdcUp, eRdyUp, eBusy;
        int eAdcDn, eAnaDn, eDigDn, eIdle;
    } vec_t;

    function automatic vec_t mkVec(input int d, a, c, s, du, au, cu, ru, bc, cd, ad, dd, il);
        vec_t v;
        v.dig = d; v.ana = a; v.adc = c; v.sd = s;
        v.eDigUp = du; v.eAnaUp = au; v.eAdcUp = cu; v.eRdyUp = ru; v.eBusy = bc;
        v.eAdcDn = cd; v.eAnaDn = ad; v.eDigDn = dd; v.eIdle = il;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", testsRun, testsFailed);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[3];
        int   n;
        bit   adcSeen;

        // Cycle numbers count edges from the one that samples the request.
        vecs[0] = mkVec(3, 5, 2, 4,  1, 5, 11, 14, 13,  1, 6, 11, 12);
        vecs[1] = mkVec(0, 0, 0, 0,  1, 2, 3, 4, 3,     1, 2, 3, 4);
        vecs[2] = mkVec(1, 0, 7, 2,  1, 3, 4, 12, 11,   1, 4, 7, 8);

        reset_n = 1'b0; PowerPulsingEnable = 1'b1; AcqStart = 1'b0; AcqStop = 1'b0;
        setDelays(0, 0, 0, 0);
        tick(); tick();
        check("resetState", 32'(dutOut()), 32'h0);
        $display("[TB] reset: outputs %b", dutOut());
        reset_n = 1'b1;
        tick();
        check("idleAfterReset", 32'(dutOut()), 32'h0);

        for (int i = 0; i < 3; i++) begin
            int t, digUp, anaUp, adcUp, rdyUp, busyCnt, adcDn, anaDn, digDn, idleAt;
            digUp = -1; anaUp = -1; adcUp = -1; rdyUp = -1; busyCnt = 0;
            adcDn = -1; anaDn = -1; digDn = -1; idleAt = -1;
            setDelays(vecs[i].dig, vecs[i].ana, vecs[i].adc, vecs[i].sd);
            AcqStart = 1'b1; tick(); AcqStart = 1'b0;
            t = 1;
            while (t <= 80) begin
                if (PowerOnDigital && digUp < 0) digUp = t;
                if (PowerOnAnalog && anaUp < 0)  anaUp = t;
                if (PowerOnAdc && adcUp < 0)     adcUp = t;
                if (SequencerBusy)               busyCnt++;
                if (PowerReady) begin rdyUp = t; break; end
                tick(); t++;
            end
            AcqStop = 1'b1; tick(); AcqStop = 1'b0;
            t = 1;
            while (t <= 80) begin
                if (!PowerOnAdc && adcDn < 0)     adcDn = t;
                if (!PowerOnAnalog && anaDn < 0)  anaDn = t;
                if (!PowerOnDigital && digDn < 0) digDn = t;
                if (!SequencerBusy && !PowerReady) begin idleAt = t; break; end
                tick(); t++;
            end
            check($sformatf("vec%0d.digUp", i),  32'(digUp),  32'(vecs[i].eDigUp));
            check($sformatf("vec%0d.anaUp", i),  32'(anaUp),  32'(vecs[i].eAnaUp));
            check($sformatf("vec%0d.adcUp", i),  32'(adcUp),  32'(vecs[i].eAdcUp));
            check($sformatf("vec%0d.ready", i),  32'(rdyUp),  32'(vecs[i].eRdyUp));
            check($sformatf("vec%0d.busy", i),   32'(busyCnt), 32'(vecs[i].eBusy));
            check($sformatf("vec%0d.adcDn", i),  32'(adcDn),  32'(vecs[i].eAdcDn));
            check($sformatf("vec%0d.anaDn", i),  32'(anaDn),  32'(vecs[i].eAnaDn));
            check($sformatf("vec%0d.digDn", i),  32'(digDn),  32'(vecs[i].eDigDn));
            check($sformatf("vec%0d.idle", i),   32'(idleAt), 32'(vecs[i].eIdle));
            $display("[TB] vector %0d: up %0d/%0d/%0d ready %0d busy %0d, down %0d/%0d/%0d idle %0d",
                     i, digUp, anaUp, adcUp, rdyUp, busyCnt, adcDn, anaDn, digDn, idleAt);
        end

        // Abort while analog is powering up.
        setDelays(1, 6, 0, 3);
        adcSeen = 1'b0;
        AcqStart = 1'b1; tick(); AcqStart = 1'b0;
        n = 0;
        while (!PowerOnAnalog && n < 10) begin tick(); n++; adcSeen |= PowerOnAdc; end
        tick(); adcSeen |= PowerOnAdc;
        AcqStop = 1'b1; tick(); AcqStop = 1'b0;
        check("abortAnaOff", 32'({PowerOnDigital, PowerOnAnalog, PowerOnDac}), 32'h4);
        n = 1;
        while (PowerOnDigital && n < 20) begin tick(); n++; adcSeen |= PowerOnAdc; end
        check("abortDigLow", 32'(n), 32'(3 + 2));
        check("abortNoAdc", 32'(adcSeen), 32'h0);
        $display("[TB] abort in ANA_ON: digital low at +%0d, adc seen %0d", n, adcSeen);

        // Start during power-down is replayed, unless a stop follows it.
        setDelays(0, 0, 0, 2);
        for (int pass = 0; pass < 2; pass++) begin
            AcqStart = 1'b1; tick(); AcqStart = 1'b0;
            n = 0;
            while (!PowerReady && n < 10) begin tick(); n++; end
            AcqStop = 1'b1; tick(); AcqStop = 1'b0;
            n = 0;
            while (PowerOnAnalog && n < 10) begin tick(); n++; end
            AcqStart = 1'b1; tick(); AcqStart = 1'b0;
            if (pass == 1) begin AcqStop = 1'b1; tick(); AcqStop = 1'b0; end
            n = 0;
            while (SequencerBusy && n < 20) begin tick(); n++; end
            check($sformatf("pend%0d.idle", pass), 32'(dutOut()), 32'h0);
            tick();
            if (pass == 0) begin
                check("autoRestart", 32'({PowerOnDigital, SequencerBusy}), 32'h3);
                n = 0;
                while (!PowerReady && n < 10) begin tick(); n++; end
                AcqStop = 1'b1; tick(); AcqStop = 1'b0;
                n = 0;
                while (SequencerBusy && n < 20) begin tick(); n++; end
            end else begin
                tick(); tick();
                check("noReplay", 32'(dutOut()), 32'h0);
            end
            $display("[TB] pending pass %0d: outputs %b", pass, dutOut());
        end

        // Enable drop, re-enable and reset in the middle of a sequence.
        setDelays(0, 0, 5, 1);
        AcqStart = 1'b1; tick(); AcqStart = 1'b0;
        n = 0;
        while (!PowerOnAdc && n < 10) begin tick(); n++; end
        PowerPulsingEnable = 1'b0; tick();
        check("disableForcesOn", 32'(dutOut()), 32'h3E);
        AcqStart = 1'b1; tick(); AcqStart = 1'b0;
        check("disableIgnoresStart", 32'(dutOut()), 32'h3E);
        PowerPulsingEnable = 1'b1; tick();
        check("reenableIdle", 32'(dutOut()), 32'h0);
        AcqStart = 1'b1; tick(); AcqStart = 1'b0; tick(); tick();
        reset_n = 1'b0; tick();
        check("resetMidSeq", 32'(dutOut()), 32'h0);
        PowerPulsingEnable = 1'b0; tick();
        check("resetOverridesDisable", 32'(dutOut()), 32'h0);
        reset_n = 1'b1; tick();
        check("disableAfterReset", 32'(dutOut()), 32'h3E);
        PowerPulsingEnable = 1'b1; tick();
        check("enableAfterReset", 32'(dutOut()), 32'h0);
        $display("[TB] enable/reset sequence done, outputs %b", dutOut());

        // Randomized traffic; delay inputs also move mid-dwell.
        for (int c = 0; c < 4000; c++) begin
            reset_n            = ($urandom_range(0, 299) != 0);
            PowerPulsingEnable = ($urandom_range(0, 79) != 0);
            AcqStart           = ($urandom_range(0, 7) == 0);
            AcqStop            = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) DigitalDelay  = CW'($urandom_range(0, 6));
            if ($urandom_range(0, 7) == 0) AnalogDelay   = CW'($urandom_range(0, 6));
            if ($urandom_range(0, 7) == 0) AdcDelay      = CW'($urandom_range(0, 6));
            if ($urandom_range(0, 7) == 0) ShutdownDelay = CW'($urandom_range(0, 6));
            tick();
        end
        $display("[TB] random: 4000 cycles, %0d failed so far", testsFailed);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
